pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit for the MIPS fetch stage.
- Replaces the plain PC register and +4 adder pair with a single registered next-PC selector.
- Supports stall, branch/jump redirect, an optional architectural branch delay slot, exception vectoring and misaligned-target trapping.
- Feeds instruction-memory address and link value to the decode stage.

Parameters:
- WIDTH, 32, PC width in bits.
- INC, 4, sequential increment in bytes. Power of two, ≥1.
- RESET_VECTOR, 32'h0000_0000, PC value loaded by RESET.
- EXC_VECTOR, 32'h8000_0180, PC value loaded on exception or misaligned target.
- DELAY_SLOT, 1. 1 means redirects take effect after one delay-slot instruction; 0 means redirects take effect on the next fetch.

Ports:
- CLK, input, 1, clock. All state updates on the rising edge.
- RESET, input, 1, synchronous active-high reset.
- EN, input, 1, fetch enable. 0 stalls the PC.
- BR_TAKEN, input, 1, resolved conditional branch taken.
- BR_TARGET, input, WIDTH, branch target.
- JUMP, input, 1, unconditional jump/jump-register.
- JUMP_TARGET, input, WIDTH, jump target.
- EXC, input, 1, exception request.
- PC_OUT, output, WIDTH, current fetch address (registered).
- LINK_OUT, output, WIDTH, return address. Equals PC_OUT+2*INC if DELAY_SLOT=1, else PC_OUT+INC. Combinational from the PC register.
- PC_VALID, output, 1, PC_OUT holds a fetchable address.
- SLOT_PENDING, output, 1, FSM is in state SLOT.
- MISALIGN, output, 1, one-cycle pulse on a misaligned redirect target.

Behaviour:
- All arithmetic is unsigned modulo 2^WIDTH. PC_OUT+INC at all-ones wraps to 0 with no flag.
- Misaligned means any of the low log2(INC) bits of the selected target are nonzero. With INC=1, no target is ever misaligned.
- Reset, sampled at the clock edge:
  - PC_OUT=RESET_VECTOR, state=SEQ, pending target=0.
  - PC_VALID=0, MISALIGN=0, SLOT_PENDING=0.
  - RESET overrides every other input. Reset mid-slot discards the pending target.
- PC_VALID goes to 1 on the first edge after RESET deasserts and stays 1 until the next reset.
- Redirect target selection: JUMP has priority over BR_TAKEN; use JUMP_TARGET if JUMP=1, else BR_TARGET. A redirect is requested when JUMP or BR_TAKEN is 1.
- Priority per edge, with RESET=0:
  1. EXC=1, regardless of EN or state: PC_OUT<=EXC_VECTOR, state<=SEQ, pending cleared, MISALIGN<=0.
  2. EN=0: all registers hold and MISALIGN<=0. Redirect requests are ignored; the requester must hold them until EN=1.
  3. EN=1, state SEQ, no redirect: PC_OUT<=PC_OUT+INC.
  4. EN=1, state SEQ, redirect, target misaligned: PC_OUT<=EXC_VECTOR, MISALIGN<=1 for one cycle, state stays SEQ.
  5. EN=1, state SEQ, aligned redirect, DELAY_SLOT=0: PC_OUT<=target.
  6. EN=1, state SEQ, aligned redirect, DELAY_SLOT=1: pending<=target, PC_OUT<=PC_OUT+INC (delay-slot fetch), state<=SLOT.
  7. EN=1, state SLOT: PC_OUT<=pending, state<=SEQ. Any redirect request in this cycle (branch in delay slot) is ignored.
- Stall in SLOT holds both the state and the pending target.
- Latency: a redirect sampled at edge N appears on PC_OUT after edge N if DELAY_SLOT=0, or after edge N+1 if DELAY_SLOT=1.
- MISALIGN is registered and deasserts on the following edge unless another misaligned redirect occurs.

Test Plan:
1. Sequential fetch with wrap:
   - RESET high 2 cycles, then EN=1 for 4 cycles: PC_OUT=0 during reset, then 4, 8, 12, 16; PC_VALID=1 from the first post-reset edge; LINK_OUT=PC_OUT+8.
   - Separately, RESET_VECTOR=32'hFFFF_FFFC, one EN cycle: PC_OUT=0.
2. Delay-slot branch and stall:
   - At PC=0x10, BR_TAKEN=1, BR_TARGET=0x100: PC goes 0x14 (SLOT_PENDING=1), then 0x100.
   - Repeat with EN=0 for 3 cycles while in SLOT: PC holds 0x14 and SLOT_PENDING stays 1 until EN returns.
3. Priority and ignored slot redirect:
   - JUMP=1 (0x200) and BR_TAKEN=1 (0x300) together at PC=0x20: sequence is 0x24, then 0x200.
   - A BR_TAKEN=1 (0x400) during SLOT is ignored; the PC after the slot is 0x200.
4. Misaligned target:
   - JUMP=1, JUMP_TARGET=0x102 at PC=0x40: PC_OUT=0x8000_0180 next cycle, MISALIGN=1 for exactly one cycle, no SLOT entered.
5. Exception overrides:
   - EXC=1 while EN=0 and in SLOT (pending 0x100): PC_OUT=0x8000_0180, state SEQ; the next EN cycle gives 0x8000_0184.
   - RESET asserted in SLOT: PC_OUT=0, SLOT_PENDING=0.
6. DELAY_SLOT=0, INC=2 instance:
   - At PC=0x10, BR_TAKEN=1, BR_TARGET=0x31: MISALIGN pulse, PC_OUT=EXC_VECTOR.
   - At PC=0x10, BR_TAKEN=1, BR_TARGET=0x30: PC_OUT=0x30 on the next edge, LINK_OUT=0x32.

Source files
------------

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - registered next-PC selector for the MIPS fetch stage
//
// Ports:
//   CLK          clock, all state updates on the rising edge
//   RESET        synchronous active-high reset
//   EN           fetch enable, 0 stalls the PC
//   BR_TAKEN     resolved conditional branch taken
//   BR_TARGET    branch target
//   JUMP         unconditional jump / jump-register (wins over BR_TAKEN)
//   JUMP_TARGET  jump target
//   EXC          exception request, overrides everything but RESET
//   PC_OUT       current fetch address (registered)
//   LINK_OUT     return address, PC_OUT + 2*INC with a delay slot, else PC_OUT + INC
//   PC_VALID     PC_OUT holds a fetchable address
//   SLOT_PENDING a redirect is queued behind the delay-slot fetch
//   MISALIGN     one-cycle pulse when a redirect target was misaligned
module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter int               INC          = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int               DELAY_SLOT   = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             BR_TAKEN,
    input  logic [WIDTH-1:0] BR_TARGET,
    input  logic             JUMP,
    input  logic [WIDTH-1:0] JUMP_TARGET,
    input  logic             EXC,
    output logic [WIDTH-1:0] PC_OUT,
    output logic [WIDTH-1:0] LINK_OUT,
    output logic             PC_VALID,
    output logic             SLOT_PENDING,
    output logic             MISALIGN
);

    typedef enum logic [0:0] {
        SEQ  = 1'b0,
        SLOT = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] INC_W  = WIDTH'(INC);
    localparam logic [WIDTH-1:0] LINK_W = WIDTH'((DELAY_SLOT != 0) ? 2 * INC : INC);
    // INC is a power of two, so INC-1 masks exactly the low log2(INC) bits;
    // with INC=1 the mask is zero and no target can be misaligned.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             valid_q;
    logic             misalign_q, misalign_d;

    logic             redirect;
    logic [WIDTH-1:0] target;
    logic             target_misaligned;
    logic [WIDTH-1:0] pc_seq;

    assign redirect          = JUMP | BR_TAKEN;
    assign target            = JUMP ? JUMP_TARGET : BR_TARGET;
    assign target_misaligned = |(target & ALIGN_MASK);
    assign pc_seq            = pc_q + INC_W;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= SEQ;
            pc_q       <= RESET_VECTOR;
            pending_q  <= '0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pending_q  <= pending_d;
            valid_q    <= 1'b1;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pending_d  = pending_q;
        misalign_d = 1'b0;

        if (EXC) begin
            pc_d      = EXC_VECTOR;
            state_d   = SEQ;
            pending_d = '0;
        end else if (EN) begin
            case (state_q)
                SEQ: begin
                    if (!redirect) begin
                        pc_d = pc_seq;
                    end else if (target_misaligned) begin
                        pc_d       = EXC_VECTOR;
                        misalign_d = 1'b1;
                    end else if (DELAY_SLOT != 0) begin
                        // Fetch the delay-slot instruction first, park the target.
                        pending_d = target;
                        pc_d      = pc_seq;
                        state_d   = SLOT;
                    end else begin
                        pc_d = target;
                    end
                end
                SLOT: begin
                    // A branch sitting in the delay slot is architecturally ignored.
                    pc_d    = pending_q;
                    state_d = SEQ;
                end
                default: begin
                    state_d = SEQ;
                end
            endcase
        end
    end

    assign PC_OUT       = pc_q;
    assign LINK_OUT     = pc_q + LINK_W;
    assign PC_VALID     = valid_q;
    assign SLOT_PENDING = (state_q == SLOT);
    assign MISALIGN     = misalign_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit
module tb_pc_unit;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Instance A: default parameters (INC=4, delay slot on)
    logic        a_reset, a_en, a_br, a_j, a_exc;
    logic [31:0] a_brt, a_jt;
    logic [31:0] a_pc, a_link;
    logic        a_valid, a_slot, a_mis;

    // Instance B: reset vector at the top of the address space
    logic        b_reset, b_en;
    logic [31:0] b_pc, b_link;
    logic        b_valid, b_slot, b_mis;

    // Instance C: no delay slot, INC=2
    logic        c_reset, c_en, c_br;
    logic [31:0] c_brt;
    logic [31:0] c_pc, c_link;
    logic        c_valid, c_slot, c_mis;

    pc_unit u_a (
        .CLK(CLK), .RESET(a_reset), .EN(a_en),
        .BR_TAKEN(a_br), .BR_TARGET(a_brt),
        .JUMP(a_j), .JUMP_TARGET(a_jt), .EXC(a_exc),
        .PC_OUT(a_pc), .LINK_OUT(a_link), .PC_VALID(a_valid),
        .SLOT_PENDING(a_slot), .MISALIGN(a_mis)
    );

    pc_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) u_b (
        .CLK(CLK), .RESET(b_reset), .EN(b_en),
        .BR_TAKEN(1'b0), .BR_TARGET(32'h0),
        .JUMP(1'b0), .JUMP_TARGET(32'h0), .EXC(1'b0),
        .PC_OUT(b_pc), .LINK_OUT(b_link), .PC_VALID(b_valid),
        .SLOT_PENDING(b_slot), .MISALIGN(b_mis)
    );

    pc_unit #(.INC(2), .DELAY_SLOT(0)) u_c (
        .CLK(CLK), .RESET(c_reset), .EN(c_en),
        .BR_TAKEN(c_br), .BR_TARGET(c_brt),
        .JUMP(1'b0), .JUMP_TARGET(32'h0), .EXC(1'b0),
        .PC_OUT(c_pc), .LINK_OUT(c_link), .PC_VALID(c_valid),
        .SLOT_PENDING(c_slot), .MISALIGN(c_mis)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [31:0] pc, input logic slot, input logic mis);
        check({tag, ".pc"}, a_pc, pc);
        check({tag, ".slot"}, {31'b0, a_slot}, {31'b0, slot});
        check({tag, ".mis"}, {31'b0, a_mis}, {31'b0, mis});
    endtask

    initial begin
        a_reset = 1; a_en = 0; a_br = 0; a_j = 0; a_exc = 0; a_brt = 0; a_jt = 0;
        b_reset = 1; b_en = 0;
        c_reset = 1; c_en = 0; c_br = 0; c_brt = 0;

        // 1. reset then sequential fetch
        step();
        check_a("rst1", 32'h0, 1'b0, 1'b0);
        check("rst1.valid", {31'b0, a_valid}, 32'h0);
        check("b_rst.pc", b_pc, 32'hFFFF_FFFC);
        check("b_rst.link_wrap", b_link, 32'h4);
        check("b_rst.valid", {31'b0, b_valid}, 32'h0);
        step();
        check_a("rst2", 32'h0, 1'b0, 1'b0);

        a_reset = 0; a_en = 1;
        b_reset = 0; b_en = 1;
        c_reset = 0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("seq%0d", i), a_pc, 32'(4 * i));
            check($sformatf("seq%0d.link", i), a_link, 32'(4 * i + 8));
            check($sformatf("seq%0d.valid", i), {31'b0, a_valid}, 32'h1);
            if (i == 1) begin
                check("b_wrap.pc", b_pc, 32'h0);
                check("b_wrap.valid", {31'b0, b_valid}, 32'h1);
                b_en = 0;
            end
        end
        check("b_hold.pc", b_pc, 32'h0);

        // 2. delay-slot branch from 0x10, then a stalled slot
        a_br = 1; a_brt = 32'h100;
        step(); check_a("br.slot", 32'h14, 1'b1, 1'b0);
        check("br.link", a_link, 32'h1C);
        a_br = 0;
        step(); check_a("br.tgt", 32'h100, 1'b0, 1'b0);

        a_br = 1; a_brt = 32'h180;
        step(); check_a("st.slot", 32'h104, 1'b1, 1'b0);
        a_br = 0; a_en = 0;
        for (int i = 0; i < 3; i++) begin
            step(); check_a($sformatf("st.hold%0d", i), 32'h104, 1'b1, 1'b0);
        end
        a_en = 1;
        step(); check_a("st.tgt", 32'h180, 1'b0, 1'b0);

        // 3. JUMP beats BR_TAKEN; branch in the delay slot ignored
        a_j = 1; a_jt = 32'h200; a_br = 1; a_brt = 32'h300;
        step(); check_a("pri.slot", 32'h184, 1'b1, 1'b0);
        a_j = 0; a_br = 1; a_brt = 32'h400;
        step(); check_a("pri.tgt", 32'h200, 1'b0, 1'b0);
        a_br = 0;

        // 4. misaligned jump target
        a_j = 1; a_jt = 32'h102;
        step(); check_a("mis.trap", 32'h8000_0180, 1'b0, 1'b1);
        a_j = 0;
        step(); check_a("mis.clear", 32'h8000_0184, 1'b0, 1'b0);

        // 5. exception while stalled in a slot, then reset in a slot
        a_br = 1; a_brt = 32'h100;
        step(); check_a("exc.slot", 32'h8000_0188, 1'b1, 1'b0);
        a_br = 0; a_en = 0; a_exc = 1;
        step(); check_a("exc.vec", 32'h8000_0180, 1'b0, 1'b0);
        a_exc = 0; a_en = 1;
        step(); check_a("exc.next", 32'h8000_0184, 1'b0, 1'b0);

        a_br = 1; a_brt = 32'h100;
        step(); check_a("rs.slot", 32'h8000_0188, 1'b1, 1'b0);
        a_br = 0; a_reset = 1;
        step(); check_a("rs.rst", 32'h0, 1'b0, 1'b0);
        check("rs.valid", {31'b0, a_valid}, 32'h0);
        a_reset = 0;
        step(); check_a("rs.after", 32'h4, 1'b0, 1'b0);

        // 6. no delay slot, INC=2
        check("c.idle.pc", c_pc, 32'h0);
        c_en = 1; c_br = 1; c_brt = 32'h10;
        step();
        check("c.to10.pc", c_pc, 32'h10);
        check("c.to10.link", c_link, 32'h12);
        c_brt = 32'h31;
        step();
        check("c.mis.pc", c_pc, 32'h8000_0180);
        check("c.mis.flag", {31'b0, c_mis}, 32'h1);
        c_brt = 32'h10;
        step();
        check("c.back.pc", c_pc, 32'h10);
        check("c.back.mis", {31'b0, c_mis}, 32'h0);
        c_brt = 32'h30;
        step();
        check("c.al.pc", c_pc, 32'h30);
        check("c.al.link", c_link, 32'h32);
        check("c.al.slot", {31'b0, c_slot}, 32'h0);
        c_br = 0;
        step();
        check("c.seq.pc", c_pc, 32'h32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
